// File: rtl/alu_seq_flags.sv
// alu_seq_flags
//   Registered, width-generic ALU with a stored carry flag for multi-slice
//   arithmetic, and a multi-cycle shift-add unsigned multiply.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready input handshake carrying op, a, b
//   op[3:0], a, b       operation select and operands
//   out_valid/out_ready output handshake carrying result and flags
//   result, carry, zero, overflow, negative
//                       presented result and its flags
//   busy                multiply in progress
//   dbg_state           current FSM state (IDLE=0, MUL=1, HOLD=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready does not depend on in_valid; out_valid does not depend
// on out_ready. While out_valid is high, result and flags are held stable
// until a transfer consumes them.
module alu_seq_flags #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             overflow,
   output logic             negative,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_ADC  = 4'h8;
   localparam logic [3:0] OP_SBB  = 4'h9;
   localparam logic [3:0] OP_ASR  = 4'hA;
   localparam logic [3:0] OP_ROL  = 4'hB;
   localparam logic [3:0] OP_ROR  = 4'hC;
   localparam logic [3:0] OP_MUL  = 4'hD;
   localparam logic [3:0] OP_CMP  = 4'hE;
   localparam logic [3:0] OP_PASS = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_zero;
   logic               r_overflow;
   logic               r_negative;
   logic               r_c_st;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;

   logic               w_accept;
   logic               w_mul_last;
   logic               w_cin;
   logic               w_bin;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic               w_add_ovf;
   logic               w_sub_ovf;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_mul_hi_nz;

   assign in_ready   = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
   assign w_accept   = in_valid && in_ready;
   // Counter is loaded with WIDTH and decremented once per MUL cycle; the
   // step that brings it to zero is the last one and also presents the result.
   assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_W'(1));

   // Both carry-in and borrow-in come from the stored flag, only for ADC/SBB.
   assign w_cin  = (op == OP_ADC) && r_c_st;
   assign w_bin  = (op == OP_SBB) && r_c_st;
   assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
   assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_bin};

   assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
   assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

   // Single-cycle result for every op except MUL (MUL is finished by the
   // shift-add sequence below).
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = w_add_ovf;
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            w_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            w_v   = w_sub_ovf;
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_NOT:  w_res = ~a;
         OP_SHL: begin
            w_res = {a[WIDTH-2:0], 1'b0};
            w_c   = a[WIDTH-1];
         end
         OP_SHR: begin
            w_res = {1'b0, a[WIDTH-1:1]};
            w_c   = a[0];
         end
         OP_ASR: begin
            w_res = {a[WIDTH-1], a[WIDTH-1:1]};
            w_c   = a[0];
         end
         OP_ROL: begin
            w_res = {a[WIDTH-2:0], a[WIDTH-1]};
            w_c   = a[WIDTH-1];
         end
         OP_ROR: begin
            w_res = {a[0], a[WIDTH-1:1]};
            w_c   = a[0];
         end
         OP_PASS: w_res = b;
         default: begin
            w_res = '0;
            w_c   = 1'b0;
            w_v   = 1'b0;
         end
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set.
   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mul_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = (op == OP_MUL) ? S_MUL : S_HOLD;
            end
         end
         S_MUL: begin
            if (w_mul_last) begin
               w_state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               if (w_accept) begin
                  w_state_next = (op == OP_MUL) ? S_MUL : S_HOLD;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
         r_negative <= 1'b0;
         r_c_st     <= 1'b0;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
      end else if (w_accept) begin
         if (op == OP_MUL) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
         end else begin
            r_result   <= w_res;
            r_carry    <= w_c;
            r_zero     <= (w_res == '0);
            r_overflow <= w_v;
            r_negative <= w_res[WIDTH-1];
            r_c_st     <= w_c;
         end
      end else if (r_state == S_MUL) begin
         r_acc    <= w_acc_next;
         r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         r_cnt    <= r_cnt - CNT_W'(1);
         if (w_mul_last) begin
            r_result   <= w_acc_next[WIDTH-1:0];
            r_carry    <= w_mul_hi_nz;
            r_zero     <= (w_acc_next[WIDTH-1:0] == '0);
            r_overflow <= w_mul_hi_nz;
            r_negative <= w_acc_next[WIDTH-1];
            r_c_st     <= w_mul_hi_nz;
         end
      end
   end

   assign out_valid = (r_state == S_HOLD);
   assign busy      = (r_state == S_MUL);
   assign result    = r_result;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign overflow  = r_overflow;
   assign negative  = r_negative;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq_flags.sv
// Self-checking bench for alu_seq_flags at WIDTH=8: directed vectors with
// literal expectations, plus a behavioural model feeding an expected queue
// that is compared against every presented result.
module tb_alu_seq_flags;

   localparam int     W    = 8;
   localparam longint FULL = longint'(1) << W;
   localparam longint HALF = FULL >> 1;
   localparam longint MASK = FULL - 1;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic         overflow;
   logic         negative;
   logic         busy;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic model_cst = 1'b0;

   // Expected entries packed as {negative, overflow, zero, carry, result}.
   logic [W+3:0] exp_q[$];
   int           due_q[$];

   alu_seq_flags #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .overflow  (overflow),
      .negative  (negative),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic cst);
      longint ux, uy, sx, sy, full, st, r, cin;
      logic c, v, z, n;
      ux = longint'(x);
      uy = longint'(y);
      sx = (ux >= HALF) ? ux - FULL : ux;
      sy = (uy >= HALF) ? uy - FULL : uy;
      r = 0; c = 1'b0; v = 1'b0;
      cin = ((o == 4'h8 || o == 4'h9) && cst) ? 1 : 0;
      case (o)
         4'h0, 4'h8: begin
            full = ux + uy + cin; r = full; c = (full >= FULL);
            st = sx + sy + cin; v = (st > HALF - 1) || (st < -HALF);
         end
         4'h1, 4'h9, 4'hE: begin
            full = ux - uy - cin; r = full; c = (full < 0);
            st = sx - sy - cin; v = (st > HALF - 1) || (st < -HALF);
         end
         4'h2: r = ux & uy;
         4'h3: r = ux | uy;
         4'h4: r = ux ^ uy;
         4'h5: r = ~ux;
         4'h6: begin r = ux * 2; c = (ux >= HALF); end
         4'h7: begin r = ux / 2; c = ((ux % 2) == 1); end
         4'hA: begin r = ux / 2 + ((ux >= HALF) ? HALF : 0); c = ((ux % 2) == 1); end
         4'hB: begin r = ux * 2 + ((ux >= HALF) ? 1 : 0); c = (ux >= HALF); end
         4'hC: begin r = ux / 2 + (ux % 2) * HALF; c = ((ux % 2) == 1); end
         4'hD: begin full = ux * uy; r = full; c = (full >= FULL); v = c; end
         default: r = uy;
      endcase
      r = r & MASK;
      z = (r == 0);
      n = (r >= HALF);
      return {n, v, z, c, r[W-1:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- drivers ----------------
   // Presents op/a/b from the current time; accepts at the first edge where
   // in_ready is high and records the expected outcome just before that edge.
   task automatic send_op_now(input logic [3:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, output int waited);
      logic [W+3:0] e;
      op = o; a = x; b = y; in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      e = model(o, x, y, model_cst);
      model_cst = e[W];
      exp_q.push_back(e);
      due_q.push_back(cyc + ((o == 4'hD) ? W + 1 : 1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
   endtask

   task automatic send_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int w;
      @(posedge clk);
      #1;
      send_op_now(o, x, y, w);
   endtask

   task automatic wait_result(input string name, input logic [W-1:0] er, input logic ec,
                              input logic ez, input logic ev, input logic en);
      int k;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_result"}, 64'(result), 64'(er));
      chk({name, "_flags"}, {60'd0, carry, zero, overflow, negative}, {60'd0, ec, ez, ev, en});
   endtask

   // ---------------- scoreboard compare ----------------
   initial begin : compare
      logic prev_v;
      logic prev_pop;
      logic [W+3:0] got;
      prev_v = 1'b0;
      prev_pop = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            prev_pop = 1'b0;
         end else begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 64'(out_valid), 64'd0);
               end else begin
                  if (!prev_v || prev_pop) begin
                     chk("latency", 64'(cyc), 64'(due_q[0]));
                  end
                  got = {negative, overflow, zero, carry, result};
                  chk("model_cmp", 64'(got), 64'(exp_q[0]));
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     void'(due_q.pop_front());
                  end
               end
            end
            prev_v = out_valid;
            prev_pop = out_valid && out_ready;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   logic [3:0]   t_op[10] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hB, 4'hC, 4'hF, 4'hD, 4'h0};
   logic [W-1:0] t_a[10]  = '{8'hA5, 8'hA5, 8'hA5, 8'h0F, 8'h81, 8'h81, 8'h02, 8'h33, 8'h0F, 8'h80};
   logic [W-1:0] t_b[10]  = '{8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h80};

   initial begin : stim
      int k, busy_cnt, w;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = 4'h0; a = '0; b = '0;

      // model pins
      chk("pin_model_add", 64'(model(4'h0, 8'h7F, 8'h01, 1'b0)), 64'({4'b1100, 8'h80}));
      chk("pin_model_sbb", 64'(model(4'h9, 8'h05, 8'h02, 1'b1)), 64'({4'b0000, 8'h02}));
      chk("pin_model_mul", 64'(model(4'hD, 8'h10, 8'h20, 1'b0)), 64'({4'b0111, 8'h00}));

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_flags", {59'd0, carry, zero, overflow, negative, out_valid}, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      send_op(4'h0, 8'h7F, 8'h01);
      wait_result("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
      send_op(4'h1, 8'h00, 8'h01);
      wait_result("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
      send_op(4'h9, 8'h05, 8'h02);
      wait_result("sbb_chain", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      send_op(4'h0, 8'hFF, 8'h01);
      wait_result("add_carry", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      send_op(4'h8, 8'h00, 8'h00);
      wait_result("adc_chain", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

      // multiply timing
      send_op(4'hD, 8'h10, 8'h20);
      k = 0; busy_cnt = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (out_valid) break;
         busy_cnt += int'(busy);
         chk("mul_in_ready_low", 64'(in_ready), 64'd0);
      end
      chk("mul_latency", 64'(k), 64'(W + 1));
      chk("mul_busy_cycles", 64'(busy_cnt), 64'(W));
      chk("mul_result", 64'(result), 64'd0);
      chk("mul_flags", {60'd0, carry, zero, overflow, negative}, {60'd0, 4'b1110});

      send_op(4'hA, 8'h81, 8'h00);
      wait_result("asr", 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
      send_op(4'hE, 8'h10, 8'h20);
      wait_result("cmp", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
      send_op(4'hD, 8'hFF, 8'hFF);
      wait_result("mul_ff", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);

      // hold with out_ready low, then back-to-back consume + accept
      @(posedge clk);
      #1 out_ready = 1'b0;
      send_op(4'hC, 8'h01, 8'h00);
      wait_result("ror_hold", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_stable", {54'd0, out_valid, carry, result}, {54'd0, 1'b1, 1'b1, 8'h80});
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send_op_now(4'h6, 8'h81, 8'h00, w);
      chk("b2b_no_wait", 64'(w), 64'd0);
      wait_result("shl_b2b", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         send_op(t_op[i], t_a[i], t_b[i]);
      end

      // reset during a multiply
      send_op(4'h0, 8'hFF, 8'h01);
      wait_result("pre_rst_carry", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      send_op(4'hD, 8'h03, 8'h05);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      due_q.delete();
      model_cst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midmul_rst_result", 64'(result), 64'd0);
      chk("midmul_rst_flags", {59'd0, carry, zero, overflow, negative, out_valid}, 64'd0);
      chk("midmul_rst_busy", 64'(busy), 64'd0);
      chk("midmul_rst_in_ready", 64'(in_ready), 64'd1);
      repeat (12) @(negedge clk);
      chk("midmul_no_result", 64'(out_valid), 64'd0);
      send_op(4'h8, 8'h00, 8'h00);
      wait_result("adc_after_rst", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
